exe1_arbiter: RTL and testbench
===============================

# exe1_arbiter

Round-robin scheduler that shares one single-bit serial FSM instance (the `exe1` block, ports `clk_i`/`rst_ni`/`in1`) between `N_REQ` bit-serial requesters. For each granted frame it clears the shared FSM through its reset, then streams exactly `FRAME_LEN` bits from the owner into `in1`. It signals frame completion and rotates priority. It sits between the requesters and the `exe1` instance and owns that instance's `rst_ni` and `in1` pins.

## Interface
- `N_REQ`, default 4: number of requesters (≥2).
- `FRAME_LEN`, default 8: bits streamed per grant (≥1).

Ports:
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in `N_REQ`: level request per requester; sampled only when arbitrating.
- `bit_i` in `N_REQ`: current serial bit of each requester.
- `gnt_o` out `N_REQ`: one-hot grant, registered.
- `bit_ack_o` out `N_REQ`: high for the owner in each STREAM cycle; the requester presents its next bit after that edge.
- `fsm_rst_no` out 1: drives shared FSM `rst_ni`, registered, active-low.
- `fsm_in_o` out 1: drives shared FSM `in1`.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `frame_done_o` out 1: one-cycle pulse in DONE.

## Operation
- States are IDLE, FLUSH, STREAM, DONE.
- **IDLE**: `gnt_o`=0, `fsm_rst_no`=1. If any `req_i` bit is set, pick a winner, load `gnt_o`, and go to FLUSH.
- **FLUSH**: exactly 1 cycle. `fsm_rst_no`=0 and `gnt_o` is held. Clear the bit counter and go to STREAM.
- **STREAM**: exactly `FRAME_LEN` cycles.
  - `fsm_in_o` = `bit_i[owner]` (combinational mux); `bit_ack_o[owner]`=1.
  - The counter increments each cycle. Leave STREAM when the counter = `FRAME_LEN`-1.
- **DONE**: 1 cycle. `frame_done_o`=1 and `gnt_o` is still held. Set the priority pointer to the owner.
  - Arbitrate again using the updated pointer. If any request is pending, go to FLUSH with the new grant; otherwise go to IDLE.
- Round-robin rule: search starts at pointer+1 and wraps modulo `N_REQ`. The first set `req_i` wins. The pointer resets to `N_REQ`-1, so requester 0 has first priority after reset.
- Outside STREAM, `fsm_in_o`=0 and `bit_ack_o`=0.
- Counter width is `$clog2(FRAME_LEN)` (minimum 1 bit).
- If the owner deasserts `req_i` mid-frame, the frame still runs to completion. No abort.
- A request arriving during FLUSH, STREAM or DONE waits; it is considered at the next DONE or IDLE arbitration.
- When the owner is the only requester at DONE, it wins again (the search wraps back to it).

## Timing
- Reset values: state IDLE, `gnt_o`=0, `bit_ack_o`=0, `fsm_rst_no`=1, `fsm_in_o`=0, `busy_o`=0, `frame_done_o`=0, pointer `N_REQ`-1, counter 0.
- Asserting `rst_ni` mid-frame forces all of the above immediately (asynchronously). The interrupted frame is lost.
- Frame timeline, with the request seen at IDLE edge 0:
  - FLUSH is cycle 1.
  - STREAM is cycles 2 through `FRAME_LEN`+1.
  - DONE is cycle `FRAME_LEN`+2.
- Period of back-to-back frames: `FRAME_LEN`+2 cycles (DONE → FLUSH directly).
- The shared FSM sees `rst_ni` low for exactly one cycle before every frame. Its outputs are valid for the frame from cycle 2 onward.
- `gnt_o` is stable from FLUSH through DONE inclusive and is never multi-hot.

## Test plan
- **Reset**: hold `rst_ni`=0 with `req_i`=4'b1111 → all outputs at reset values, `busy_o`=0. Release → next state FLUSH with `gnt_o`=4'b0001.
- **Single frame**: `req_i`=4'b0100, `bit_i[2]` sequence 1,0,1,1,0,0,1,0 (`FRAME_LEN`=8) →
  - `fsm_rst_no`=0 for exactly 1 cycle;
  - `fsm_in_o` reproduces the sequence over 8 cycles with `bit_ack_o`=4'b0100;
  - `frame_done_o` pulses at cycle 10, then IDLE.
- **Rotation**: `req_i`=4'b1111 held → grant order 0, 1, 2, 3, 0. Each `gnt_o` change is 10 cycles apart, with no IDLE in between.
- **Sole repeat requester**: `req_i`=4'b0010 held → requester 1 granted repeatedly. FLUSH precedes each frame.
- **Request drop mid-frame**: owner 0 drops `req_i` at STREAM cycle 3 while `req_i[3]`=1 → the frame still streams 8 bits, then requester 3 is granted.
- **Reset mid-STREAM**: pulse `rst_ni` low at STREAM cycle 4 → outputs return to reset values immediately. After release, requester 0 has priority again.

Source files
------------

// File: rtl/exe1_arbiter.sv
// Round-robin scheduler sharing one bit-serial exe1 FSM among N_REQ requesters.
// Each grant flushes the shared FSM for one cycle, then streams FRAME_LEN bits from the owner.
module exe1_arbiter #(
    parameter int N_REQ     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] bit_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [N_REQ-1:0] bit_ack_o,
    output logic             fsm_rst_no,
    output logic             fsm_in_o,
    output logic             busy_o,
    output logic             frame_done_o
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [PW-1:0]    r_owner;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_fsm_rst_n;

    logic [PW-1:0]    w_base;
    logic [PW-1:0]    w_win_idx;
    logic [N_REQ-1:0] w_win_oh;
    logic             w_found;

    // In DONE the search starts after the current owner, which becomes the new pointer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_base    = (r_state == DONE) ? r_owner : r_ptr;
        w_found   = 1'b0;
        w_win_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            if (!w_found && req_i[(int'(w_base) + i) % N_REQ]) begin
                w_found   = 1'b1;
                w_win_idx = PW'((int'(w_base) + i) % N_REQ);
            end
        end
    end

    assign w_win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = FLUSH;
            FLUSH:   w_state_nxt = STREAM;
            STREAM:  if (r_cnt == LAST_CNT) w_state_nxt = DONE;
            DONE:    w_state_nxt = w_found ? FLUSH : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_ack_o    = '0;
        fsm_in_o     = 1'b0;
        if (r_state == STREAM) begin
            bit_ack_o = r_gnt;
            fsm_in_o  = bit_i[r_owner];
        end
        busy_o       = (r_state != IDLE);
        frame_done_o = (r_state == DONE);
    end

    // Grant, pointer, bit counter and the registered reset to the shared FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_gnt       <= '0;
            r_owner     <= '0;
            r_ptr       <= PW'(N_REQ - 1);
            r_cnt       <= '0;
            r_fsm_rst_n <= 1'b1;
        end else begin
            r_fsm_rst_n <= (w_state_nxt != FLUSH);
            case (r_state)
                IDLE, DONE: begin
                    if (r_state == DONE) r_ptr <= r_owner;
                    if (w_found) begin
                        r_gnt   <= w_win_oh;
                        r_owner <= w_win_idx;
                    end else begin
                        r_gnt   <= '0;
                    end
                end
                FLUSH:   r_cnt <= '0;
                STREAM:  r_cnt <= r_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    assign gnt_o      = r_gnt;
    assign fsm_rst_no = r_fsm_rst_n;

endmodule

// File: tb/tb_exe1_arbiter.sv
// Self-checking bench for exe1_arbiter: frame-timeline reference model plus directed scenarios.
module tb_exe1_arbiter;
    localparam int N = 4;
    localparam int F = 8;

    logic         clk_i  = 1'b0;
    logic         rst_ni = 1'b0;
    logic [N-1:0] req_i  = '0;
    logic [N-1:0] bit_i  = '0;
    logic [N-1:0] gnt_o;
    logic [N-1:0] bit_ack_o;
    logic         fsm_rst_no;
    logic         fsm_in_o;
    logic         busy_o;
    logic         frame_done_o;

    exe1_arbiter #(.N_REQ(N), .FRAME_LEN(F)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .bit_i        (bit_i),
        .gnt_o        (gnt_o),
        .bit_ack_o    (bit_ack_o),
        .fsm_rst_no   (fsm_rst_no),
        .fsm_in_o     (fsm_in_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model: position in the frame timeline (0 idle, 1 flush, 2..F+1 stream, F+2 done).
    int          m_pos;
    int          m_owner;
    int          m_ptr;
    int          bit_idx [N];
    logic [63:0] pattern [N];

    logic [N-1:0] obs_gnt, obs_ack;
    logic         obs_rst, obs_in, obs_busy, obs_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int rr(input int ptr, input logic [N-1:0] req);
        for (int k = 1; k <= N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_pos   = 0;
        m_owner = -1;
        m_ptr   = N - 1;
        for (int r = 0; r < N; r++) bit_idx[r] = 0;
    endtask

    task automatic model_clock();
        int w;
        if (!rst_ni) begin
            model_reset();
            return;
        end
        if (m_pos == 0) begin
            w = rr(m_ptr, req_i);
            if (w >= 0) begin
                m_owner = w;
                m_pos   = 1;
            end
        end else if (m_pos == F + 2) begin
            m_ptr = m_owner;
            w = rr(m_ptr, req_i);
            if (w >= 0) begin
                m_owner = w;
                m_pos   = 1;
            end else begin
                m_owner = -1;
                m_pos   = 0;
            end
        end else begin
            if (m_pos >= 2) bit_idx[m_owner]++;
            m_pos++;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e_gnt, e_ack;
        logic         e_in;
        logic         stream;
        stream = (m_pos >= 2) && (m_pos <= F + 1);
        e_gnt  = (m_pos == 0) ? '0 : ({{(N-1){1'b0}}, 1'b1} << m_owner);
        e_ack  = stream ? e_gnt : '0;
        e_in   = stream ? pattern[m_owner][bit_idx[m_owner] % 64] : 1'b0;
        obs_gnt  = gnt_o;
        obs_ack  = bit_ack_o;
        obs_rst  = fsm_rst_no;
        obs_in   = fsm_in_o;
        obs_busy = busy_o;
        obs_done = frame_done_o;
        check("gnt",    obs_gnt,  e_gnt);
        check("ack",    obs_ack,  e_ack);
        check("rst_n",  obs_rst,  m_pos != 1);
        check("fsm_in", obs_in,   e_in);
        check("busy",   obs_busy, m_pos != 0);
        check("done",   obs_done, m_pos == F + 2);
    endtask

    task automatic drive_bits();
        for (int r = 0; r < N; r++) bit_i[r] = pattern[r][bit_idx[r] % 64];
    endtask

    // One clock: drive bits after negedge, check, advance model, wait for next negedge.
    task automatic cycle();
        drive_bits();
        #1;
        check_outputs();
        model_clock();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        cycle();
        cycle();
        rst_ni = 1'b1;
    endtask

    task automatic run_until(input int pos, input int limit, input string tag);
        int n = 0;
        while (m_pos != pos && n < limit) begin
            cycle();
            n++;
        end
        if (m_pos != pos) check(tag, 0, 1);
    endtask

    initial begin
        int chg_k [8];
        logic [N-1:0] chg_g [8];
        int nchg, idle_cnt, rst_low, first_rst, done_k, ack0;
        logic [N-1:0] prev;
        logic [7:0] sbits;
        logic busy11, other_gnt;

        for (int r = 0; r < N; r++) pattern[r] = {$urandom, $urandom};
        model_reset();
        @(negedge clk_i);

        // Reset held with all requests, then rotation 0,1,2,3,0 every F+2 cycles.
        req_i = 4'b1111;
        rst_ni = 1'b0;
        cycle();
        check("rst_busy", obs_busy, 0);
        check("rst_gnt", obs_gnt, 0);
        cycle();
        rst_ni = 1'b1;
        nchg = 0; idle_cnt = 0; prev = '0;
        for (int k = 0; k <= 41; k++) begin
            cycle();
            if (k == 1) begin
                check("release_gnt", obs_gnt, 4'b0001);
                check("release_flush", obs_rst, 0);
            end
            if (k >= 1 && !obs_busy) idle_cnt++;
            if (obs_gnt != prev && nchg < 8) begin
                chg_k[nchg] = k;
                chg_g[nchg] = obs_gnt;
                nchg++;
            end
            prev = obs_gnt;
        end
        check("rot_count", nchg, 5);
        for (int i = 0; i < 5 && i < nchg; i++) begin
            check("rot_gnt", chg_g[i], 1 << (i % N));
            check("rot_time", chg_k[i], 1 + 10 * i);
        end
        check("rot_no_idle", idle_cnt, 0);
        req_i = '0;
        run_until(0, 20, "rot_drain_timeout");

        // Single frame from requester 2 with a fixed bit sequence.
        do_reset();
        pattern[2] = 64'h4D;
        req_i = 4'b0100;
        rst_low = 0; first_rst = -1; done_k = -1; sbits = '0; busy11 = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            cycle();
            if (k == 0) req_i = '0;
            if (!obs_rst) begin
                rst_low++;
                if (first_rst < 0) first_rst = k;
            end
            if (obs_done) done_k = k;
            if (k >= 2 && k <= 9) sbits[k-2] = obs_in;
            if (k == 11) busy11 = obs_busy;
        end
        check("single_flush_cnt", rst_low, 1);
        check("single_flush_at", first_rst, 1);
        check("single_bits", sbits, 8'h4D);
        check("single_done_at", done_k, 10);
        check("single_idle", busy11, 0);

        // Sole repeat requester 1: three flushes in 21 cycles, never another grant.
        req_i = 4'b0010;
        rst_low = 0; other_gnt = 1'b0;
        for (int k = 0; k <= 21; k++) begin
            cycle();
            if (!obs_rst) rst_low++;
            if (obs_gnt != '0 && obs_gnt != 4'b0010) other_gnt = 1'b1;
        end
        check("sole_flushes", rst_low, 3);
        check("sole_other_gnt", other_gnt, 0);
        req_i = '0;
        run_until(0, 20, "sole_drain_timeout");

        // Owner 0 drops its request at stream cycle 3; requester 3 is next.
        do_reset();
        req_i = 4'b1001;
        cycle();
        ack0 = 0;
        run_until(4, 10, "drop_reach_timeout");
        req_i = 4'b1000;
        for (int k = 0; k < 20 && m_pos != 1; k++) begin
            cycle();
            if (obs_ack == 4'b0001) ack0++;
        end
        cycle();
        check("drop_ack_cnt", ack0 + 2, 8);
        check("drop_next_gnt", obs_gnt, 4'b1000);
        req_i = '0;
        run_until(0, 20, "drop_drain_timeout");

        // Asynchronous reset during stream cycle 4, then requester 0 has priority again.
        do_reset();
        req_i = 4'b0100;
        run_until(5, 10, "mid_reach_timeout");
        drive_bits();
        #1;
        check_outputs();
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("mid_rst_busy", obs_busy, 0);
        check("mid_rst_gnt", obs_gnt, 0);
        @(negedge clk_i);
        cycle();
        rst_ni = 1'b1;
        req_i = 4'b1111;
        cycle();
        cycle();
        check("mid_rst_prio", obs_gnt, 4'b0001);

        // Random requests against the model, with one reset in the middle.
        for (int r = 0; r < N; r++) pattern[r] = {$urandom, $urandom};
        for (int i = 0; i < 600; i++) begin
            req_i = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            rst_ni = (i != 300);
            cycle();
        end
        rst_ni = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
